// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_pkg
// Description : Shared types and constants for the scan index sequencer:
//               FSM state encoding, select width, default blanking length
//               and the load clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

    localparam int          SEL_W         = 3;
    localparam int unsigned BLANK_CYC_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_e;

    // Forced index values are limited to the active scan range.
    function automatic logic [SEL_W-1:0] clamp_sel(
        input logic [SEL_W-1:0] val,
        input logic [SEL_W-1:0] lim
    );
        return (val > lim) ? lim : val;
    endfunction

endpackage : scan_pkg
`default_nettype wire

// File: rtl/scan_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : scan_prescaler
// Description : DIV_W-bit up counter with synchronous clear and count enable.
//               tc flags the cycle in which the count equals div.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [DIV_W-1:0] div,
    output logic             tc
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    // Clear wins over increment so a step cycle restarts the period at 0.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + DIV_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == div);

endmodule : scan_prescaler
`default_nettype wire

// File: rtl/scan_index_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scan_index_sequencer
// Description : Generates the 3-bit select index for a 3-to-8 one-hot
//               decoder. Steps up or down at a programmable rate, wraps at a
//               programmable last index and blanks the outputs for
//               BLANK_CYC cycles after every step.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_index_sequencer #(
    parameter int          DIV_W     = 16,
    parameter int unsigned BLANK_CYC = scan_pkg::BLANK_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       dir,
    input  logic [scan_pkg::SEL_W-1:0] last,
    input  logic [DIV_W-1:0]           div,
    input  logic                       load,
    input  logic [scan_pkg::SEL_W-1:0] load_val,
    output logic [scan_pkg::SEL_W-1:0] sel,
    output logic                       tick,
    output logic                       wrap,
    output logic                       blank
);

    import scan_pkg::*;

    localparam int          BCNT_W     = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int unsigned BLANK_LAST = (BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0;

    scan_state_e        state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               tick_q, tick_d;
    logic               wrap_q, wrap_d;
    logic               blank_q, blank_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;

    logic               ps_clr;
    logic               ps_inc;
    logic               ps_tc;
    logic [SEL_W-1:0]   step_sel;
    logic               step_wrap;

    scan_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (ps_clr),
        .inc (ps_inc),
        .div (div),
        .tc  (ps_tc)
    );

    // Next index for a step; an out-of-range index snaps back into range.
    always_comb begin
        step_sel  = sel_q;
        step_wrap = 1'b0;
        if (!dir) begin
            if (sel_q >= last) begin
                step_sel  = '0;
                step_wrap = 1'b1;
            end else begin
                step_sel = sel_q + SEL_W'(1);
            end
        end else begin
            if (sel_q == '0) begin
                step_sel  = last;
                step_wrap = 1'b1;
            end else if (sel_q > last) begin
                step_sel = last;
            end else begin
                step_sel = sel_q - SEL_W'(1);
            end
        end
    end

    // FSM next state and registered-output next values; load overrides all.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        blank_d = blank_q;
        bcnt_d  = bcnt_q;
        ps_clr  = 1'b0;
        ps_inc  = 1'b0;

        if (load) begin
            sel_d  = clamp_sel(load_val, last);
            ps_clr = 1'b1;
            bcnt_d = '0;
            if (!en) begin
                state_d = ST_IDLE;
                blank_d = 1'b1;
            end else if (BLANK_CYC == 0) begin
                state_d = ST_RUN;
                blank_d = 1'b0;
            end else begin
                state_d = ST_BLANK;
                blank_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    ps_clr  = 1'b1;
                    blank_d = 1'b1;
                    if (en) begin
                        state_d = ST_RUN;
                        blank_d = 1'b0;
                    end
                end
                ST_RUN: begin
                    blank_d = 1'b0;
                    if (!en) begin
                        // A step falling in this cycle is dropped.
                        state_d = ST_IDLE;
                        blank_d = 1'b1;
                        ps_clr  = 1'b1;
                    end else if (ps_tc) begin
                        sel_d  = step_sel;
                        tick_d = 1'b1;
                        wrap_d = step_wrap;
                        ps_clr = 1'b1;
                        if (BLANK_CYC != 0) begin
                            state_d = ST_BLANK;
                            blank_d = 1'b1;
                            bcnt_d  = '0;
                        end
                    end else begin
                        ps_inc = 1'b1;
                    end
                end
                ST_BLANK: begin
                    ps_clr = 1'b1;
                    if (!en) begin
                        state_d = ST_IDLE;
                        blank_d = 1'b1;
                    end else if (bcnt_q == BCNT_W'(BLANK_LAST)) begin
                        state_d = ST_RUN;
                        blank_d = 1'b0;
                    end else begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    blank_d = 1'b1;
                    ps_clr  = 1'b1;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            blank_q <= 1'b1;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            blank_q <= blank_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign sel   = sel_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;
    assign blank = blank_q;

endmodule : scan_index_sequencer
`default_nettype wire

// File: tb/tb_scan_index_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_index_sequencer
// Description : Scoreboard bench for scan_index_sequencer. Two instances
//               (one blanking cycle, no blanking) share the stimulus; a
//               behavioural model predicts each cycle's outputs into queues
//               that a monitor drains and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_index_sequencer;

    localparam int DIV_W   = 16;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_BLANK = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             dir;
    logic [2:0]       last;
    logic [DIV_W-1:0] div;
    logic             load;
    logic [2:0]       load_val;

    logic [2:0] sel0, sel1;
    logic       tick0, tick1, wrap0, wrap1, blank0, blank1;

    scan_index_sequencer #(.DIV_W(DIV_W), .BLANK_CYC(1)) u_dut (
        .clk (clk), .rst (rst), .en (en), .dir (dir), .last (last),
        .div (div), .load (load), .load_val (load_val),
        .sel (sel0), .tick (tick0), .wrap (wrap0), .blank (blank0)
    );

    scan_index_sequencer #(.DIV_W(DIV_W), .BLANK_CYC(0)) u_fast (
        .clk (clk), .rst (rst), .en (en), .dir (dir), .last (last),
        .div (div), .load (load), .load_val (load_val),
        .sel (sel1), .tick (tick1), .wrap (wrap1), .blank (blank1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic       tick;
        logic       wrap;
        logic       blank;
    } obs_t;

    obs_t exp_q0[$];
    obs_t exp_q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model state, index 0 = one blanking cycle, 1 = none.
    int m_mode[2];
    int m_cnt[2];
    int m_bl[2];
    int m_sel[2];
    bit m_tick[2];
    bit m_wrap[2];
    bit m_blank[2];

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_step(input int m);
        int bc;
        int s;
        int lst;
        bc  = (m == 0) ? 1 : 0;
        s   = m_sel[m];
        lst = int'(last);
        m_tick[m] = 1'b0;
        m_wrap[m] = 1'b0;
        if (rst) begin
            m_sel[m] = 0; m_blank[m] = 1'b1; m_mode[m] = M_IDLE;
            m_cnt[m] = 0; m_bl[m] = 0;
        end else if (load) begin
            m_sel[m] = (int'(load_val) > lst) ? lst : int'(load_val);
            m_cnt[m] = 0;
            if (en && bc > 0) begin
                m_mode[m] = M_BLANK; m_bl[m] = bc; m_blank[m] = 1'b1;
            end else if (en) begin
                m_mode[m] = M_RUN; m_blank[m] = 1'b0;
            end else begin
                m_mode[m] = M_IDLE; m_blank[m] = 1'b1;
            end
        end else begin
            case (m_mode[m])
                M_IDLE: begin
                    m_blank[m] = !en;
                    if (en) begin
                        m_mode[m] = M_RUN; m_cnt[m] = 0;
                    end
                end
                M_RUN: begin
                    if (!en) begin
                        m_mode[m] = M_IDLE; m_cnt[m] = 0; m_blank[m] = 1'b1;
                    end else if (m_cnt[m] == int'(div)) begin
                        m_tick[m] = 1'b1;
                        m_cnt[m]  = 0;
                        if (!dir) begin
                            if (s >= lst) begin m_sel[m] = 0; m_wrap[m] = 1'b1; end
                            else m_sel[m] = s + 1;
                        end else begin
                            if (s == 0) begin m_sel[m] = lst; m_wrap[m] = 1'b1; end
                            else if (s > lst) m_sel[m] = lst;
                            else m_sel[m] = s - 1;
                        end
                        if (bc > 0) begin
                            m_mode[m] = M_BLANK; m_bl[m] = bc; m_blank[m] = 1'b1;
                        end else begin
                            m_blank[m] = 1'b0;
                        end
                    end else begin
                        m_cnt[m] = m_cnt[m] + 1;
                    end
                end
                M_BLANK: begin
                    if (!en) begin
                        m_mode[m] = M_IDLE; m_cnt[m] = 0; m_blank[m] = 1'b1;
                    end else begin
                        m_bl[m] = m_bl[m] - 1;
                        if (m_bl[m] == 0) begin
                            m_mode[m] = M_RUN; m_blank[m] = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Predict the outputs after the coming edge, queue them, then wait a cycle.
    task automatic drive_cycle();
        obs_t e;
        for (int m = 0; m < 2; m++) begin
            model_step(m);
            e.sel   = 3'(m_sel[m]);
            e.tick  = m_tick[m];
            e.wrap  = m_wrap[m];
            e.blank = m_blank[m];
            if (m == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic compare(input int inst, input obs_t e, input obs_t a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL out inst%0d cyc%0d: got sel=%0d tick=%0b wrap=%0b blank=%0b, exp sel=%0d tick=%0b wrap=%0b blank=%0b",
                     inst, cyc, a.sel, a.tick, a.wrap, a.blank, e.sel, e.tick, e.wrap, e.blank);
        end
    endtask

    task automatic bound_check(input bit reached, input string name);
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL wait %s: condition not reached, required within bound", name);
        end
    endtask

    // Monitor: every cycle the registered outputs are a valid observation.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                compare(0, e, {sel0, tick0, wrap0, blank0});
            end
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                compare(1, e, {sel1, tick1, wrap1, blank1});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    // Stimulus: directed scenarios followed by a randomized soak.
    initial begin
        bit hit;
        rst = 1'b1; en = 1'b0; dir = 1'b0; last = 3'd7; div = '0;
        load = 1'b0; load_val = 3'd0;
        for (int m = 0; m < 2; m++) begin
            m_mode[m] = M_IDLE; m_cnt[m] = 0; m_bl[m] = 0; m_sel[m] = 0;
            m_tick[m] = 1'b0; m_wrap[m] = 1'b0; m_blank[m] = 1'b1;
        end
        repeat (2) drive_cycle();

        // Up scan with wrap at 7.
        rst = 1'b0; div = 16'd2; last = 3'd7; dir = 1'b0; en = 1'b1;
        repeat (40) drive_cycle();

        // Down scan over 0..4 starting from 0.
        dir = 1'b1; last = 3'd4; load = 1'b1; load_val = 3'd0;
        drive_cycle();
        load = 1'b0;
        repeat (26) drive_cycle();
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if (m_sel[0] == 4) hit = 1'b1;
            else drive_cycle();
        end
        bound_check(hit, "sel4");
        last = 3'd2;
        repeat (10) drive_cycle();

        // Load clamp, then an up step wraps from the clamped last.
        dir = 1'b0; last = 3'd3; load = 1'b1; load_val = 3'd5;
        drive_cycle();
        load = 1'b0;
        repeat (20) drive_cycle();

        // Drop enable exactly on a step cycle.
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (m_mode[0] == M_RUN && m_cnt[0] == int'(div)) hit = 1'b1;
            else drive_cycle();
        end
        bound_check(hit, "stepcycle");
        en = 1'b0;
        repeat (3) drive_cycle();
        en = 1'b1;
        repeat (12) drive_cycle();

        // Reset while blanking with sel=6.
        last = 3'd7; dir = 1'b0; div = 16'd1; load = 1'b1; load_val = 3'd5;
        drive_cycle();
        load = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (m_mode[0] == M_BLANK && m_sel[0] == 6) hit = 1'b1;
            else drive_cycle();
        end
        bound_check(hit, "blank6");
        rst = 1'b1;
        drive_cycle();
        rst = 1'b0;
        repeat (4) drive_cycle();

        // Fast mode: div=0 (second instance has no blanking).
        div = '0; last = 3'd7; dir = 1'b0; load = 1'b1; load_val = 3'd0;
        drive_cycle();
        load = 1'b0;
        repeat (24) drive_cycle();

        // Randomized soak; div only changes when the prescaler restarts.
        for (int k = 0; k < 400; k++) begin
            rst      = ($urandom_range(0, 99) == 0);
            load     = ($urandom_range(0, 19) == 0);
            en       = ($urandom_range(0, 9) != 0);
            load_val = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) dir  = ~dir;
            if ($urandom_range(0, 15) == 0) last = 3'($urandom_range(0, 7));
            if (rst || load) div = DIV_W'($urandom_range(0, 3));
            drive_cycle();
        end
        rst = 1'b0; load = 1'b0;

        @(posedge clk);
        #3;
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending, required 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_scan_index_sequencer
`default_nettype wire
